// File: rtl/io_rr_arbiter_pkg.sv
// ============================================================================
//  Module      : io_arb_pkg
//  Description : Shared defaults and helpers for the IO round-robin arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package io_arb_pkg;

    localparam int NM_DEF     = 2;
    localparam int RD_LAT_DEF = 1;

    // Address bit that selects the IO region in the core memory map
    localparam int IO_SEL_BIT = 22;

    function automatic int id_w(input int nm);
        return (nm > 1) ? $clog2(nm) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/io_rr_arbiter_rr_pick.sv
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational rotating-priority picker (first req at/after ptr).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
    import io_arb_pkg::*;
#(
    parameter int NM = NM_DEF
) (
    input  logic [NM-1:0]          req,
    input  logic [id_w(NM)-1:0]    ptr,
    output logic [NM-1:0]          gnt,
    output logic [id_w(NM)-1:0]    idx,
    output logic                   any
);

    localparam int IW = id_w(NM);

    // Scan from farthest to nearest so the candidate closest to ptr wins last
    always_comb begin : p_pick
        int c;
        gnt = '0;
        idx = '0;
        any = |req;
        c   = 0;
        for (int k = NM - 1; k >= 0; k--) begin
            c = (int'(ptr) + k) % NM;
            if (req[c]) begin
                gnt    = '0;
                gnt[c] = 1'b1;
                idx    = IW'(c);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/io_rr_arbiter.sv
// ============================================================================
//  Module      : io_rr_arbiter
//  Description : Round-robin arbiter sharing one IO slave among NM masters,
//                with in-order read response routing.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module io_rr_arbiter
    import io_arb_pkg::*;
#(
    parameter int NM     = NM_DEF,
    parameter int RD_LAT = RD_LAT_DEF,
    parameter int AW     = 32,
    parameter int DW     = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NM-1:0]        m_req,
    input  logic [NM-1:0]        m_we,
    input  logic [NM*AW-1:0]     m_addr,
    input  logic [NM*DW-1:0]     m_wdata,
    output logic [NM-1:0]        m_gnt,
    output logic [NM-1:0]        m_rvalid,
    output logic [DW-1:0]        m_rdata,
    output logic [AW-1:0]        s_addr,
    output logic [DW-1:0]        s_wdata,
    output logic                 s_wr,
    output logic                 s_rd,
    input  logic [DW-1:0]        s_rdata
);

    localparam int            IW        = id_w(NM);
    localparam logic [IW-1:0] C_LAST_ID = IW'(NM - 1);

    logic [NM-1:0]             w_req;
    logic [NM-1:0]             w_gnt;
    logic [IW-1:0]             w_idx;
    logic                      w_any;

    logic [IW-1:0]             ptr_q, ptr_d;
    logic [AW-1:0]             s_addr_q, s_addr_d;
    logic [DW-1:0]             s_wdata_q, s_wdata_d;
    logic                      s_wr_q, s_wr_d;
    logic                      s_rd_q, s_rd_d;
    logic [IW-1:0]             cmd_id_q, cmd_id_d;
    logic [RD_LAT-1:0]         rd_vld_q;
    logic [RD_LAT-1:0][IW-1:0] rd_id_q;
    logic [NM-1:0]             m_rvalid_q, m_rvalid_d;
    logic [DW-1:0]             m_rdata_q;

    // Requests are masked during reset so no grant escapes
    assign w_req = resetn ? m_req : '0;

    rr_pick #(
        .NM  (NM)
    ) u_pick (
        .req (w_req),
        .ptr (ptr_q),
        .gnt (w_gnt),
        .idx (w_idx),
        .any (w_any)
    );

    always_comb begin
        ptr_d     = ptr_q;
        s_addr_d  = s_addr_q;
        s_wdata_d = s_wdata_q;
        s_wr_d    = 1'b0;
        s_rd_d    = 1'b0;
        cmd_id_d  = cmd_id_q;
        if (w_any) begin
            ptr_d     = (w_idx == C_LAST_ID) ? '0 : w_idx + IW'(1);
            s_addr_d  = m_addr[w_idx*AW +: AW];
            s_wdata_d = m_wdata[w_idx*DW +: DW];
            s_wr_d    = m_we[w_idx];
            s_rd_d    = ~m_we[w_idx];
            cmd_id_d  = w_idx;
        end
    end

    for (genvar j = 0; j < NM; j++) begin : g_rvalid
        assign m_rvalid_d[j] = rd_vld_q[RD_LAT-1] && (rd_id_q[RD_LAT-1] == IW'(j));
    end

    // Stage 0 of the id pipe follows s_rd, so the tail lines up with s_rdata
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ptr_q      <= '0;
            s_addr_q   <= '0;
            s_wdata_q  <= '0;
            s_wr_q     <= 1'b0;
            s_rd_q     <= 1'b0;
            cmd_id_q   <= '0;
            rd_vld_q   <= '0;
            rd_id_q    <= '0;
            m_rvalid_q <= '0;
            m_rdata_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            s_addr_q    <= s_addr_d;
            s_wdata_q   <= s_wdata_d;
            s_wr_q      <= s_wr_d;
            s_rd_q      <= s_rd_d;
            cmd_id_q    <= cmd_id_d;
            rd_vld_q[0] <= s_rd_q;
            rd_id_q[0]  <= cmd_id_q;
            for (int k = 1; k < RD_LAT; k++) begin
                rd_vld_q[k] <= rd_vld_q[k-1];
                rd_id_q[k]  <= rd_id_q[k-1];
            end
            m_rvalid_q <= m_rvalid_d;
            if (rd_vld_q[RD_LAT-1]) begin
                m_rdata_q <= s_rdata;
            end
        end
    end

    assign m_gnt    = w_gnt;
    assign m_rvalid = m_rvalid_q;
    assign m_rdata  = m_rdata_q;
    assign s_addr   = s_addr_q;
    assign s_wdata  = s_wdata_q;
    assign s_wr     = s_wr_q;
    assign s_rd     = s_rd_q;

endmodule

`default_nettype wire

// File: tb/tb_io_rr_arbiter.sv
// ============================================================================
//  Module      : tb_io_rr_arbiter
//  Description : Bench for io_rr_arbiter: three instances (NM=2/RD_LAT=1,
//                NM=2/RD_LAT=2, NM=3/RD_LAT=1) against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_io_rr_arbiter;

    localparam logic [31:0] C_KEY = 32'hA5A5_A5A5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic [2:0]  rq [3];
    logic [2:0]  we [3];
    logic [31:0] ad [3][3];
    logic [31:0] wd [3][3];
    logic [31:0] h0 [3];
    logic [31:0] h1 [3];

    logic [1:0]  gnt_a, rv_a, gnt_b, rv_b;
    logic [2:0]  gnt_c, rv_c;
    logic [31:0] rdat_a, rdat_b, rdat_c, saddr_a, saddr_b, saddr_c, swd_a, swd_b, swd_c;
    logic        swr_a, swr_b, swr_c, srd_a, srd_b, srd_c;

    logic [2:0]  gnt_v [3];
    logic [2:0]  rv_v [3];
    logic [31:0] rdat_v [3];
    logic [31:0] saddr_v [3];
    logic [31:0] swd_v [3];
    logic        swr_v [3];
    logic        srd_v [3];

    assign gnt_v[0] = {1'b0, gnt_a};  assign gnt_v[1] = {1'b0, gnt_b};  assign gnt_v[2] = gnt_c;
    assign rv_v[0]  = {1'b0, rv_a};   assign rv_v[1]  = {1'b0, rv_b};   assign rv_v[2]  = rv_c;
    assign rdat_v[0] = rdat_a;  assign rdat_v[1] = rdat_b;  assign rdat_v[2] = rdat_c;
    assign saddr_v[0] = saddr_a; assign saddr_v[1] = saddr_b; assign saddr_v[2] = saddr_c;
    assign swd_v[0] = swd_a;  assign swd_v[1] = swd_b;  assign swd_v[2] = swd_c;
    assign swr_v[0] = swr_a;  assign swr_v[1] = swr_b;  assign swr_v[2] = swr_c;
    assign srd_v[0] = srd_a;  assign srd_v[1] = srd_b;  assign srd_v[2] = srd_c;

    io_rr_arbiter #(.NM(2), .RD_LAT(1), .AW(32), .DW(32)) u_dut_a (
        .clk(clk), .resetn(resetn), .m_req(rq[0][1:0]), .m_we(we[0][1:0]),
        .m_addr({ad[0][1], ad[0][0]}), .m_wdata({wd[0][1], wd[0][0]}),
        .m_gnt(gnt_a), .m_rvalid(rv_a), .m_rdata(rdat_a), .s_addr(saddr_a),
        .s_wdata(swd_a), .s_wr(swr_a), .s_rd(srd_a), .s_rdata(h0[0] ^ C_KEY));

    io_rr_arbiter #(.NM(2), .RD_LAT(2), .AW(32), .DW(32)) u_dut_b (
        .clk(clk), .resetn(resetn), .m_req(rq[1][1:0]), .m_we(we[1][1:0]),
        .m_addr({ad[1][1], ad[1][0]}), .m_wdata({wd[1][1], wd[1][0]}),
        .m_gnt(gnt_b), .m_rvalid(rv_b), .m_rdata(rdat_b), .s_addr(saddr_b),
        .s_wdata(swd_b), .s_wr(swr_b), .s_rd(srd_b), .s_rdata(h1[1] ^ C_KEY));

    io_rr_arbiter #(.NM(3), .RD_LAT(1), .AW(32), .DW(32)) u_dut_c (
        .clk(clk), .resetn(resetn), .m_req(rq[2]), .m_we(we[2]),
        .m_addr({ad[2][2], ad[2][1], ad[2][0]}), .m_wdata({wd[2][2], wd[2][1], wd[2][0]}),
        .m_gnt(gnt_c), .m_rvalid(rv_c), .m_rdata(rdat_c), .s_addr(saddr_c),
        .s_wdata(swd_c), .s_wr(swr_c), .s_rd(srd_c), .s_rdata(h0[2] ^ C_KEY));

    // Slave model: read data is the address seen on the bus, xor a key, delayed
    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            h0[d] <= saddr_v[d];
            h1[d] <= h0[d];
        end
    end

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Behavioural reference: a priority pointer, the command last issued, and a
    // per-cycle calendar of the responses each instance owes its masters.
    int          ptr [3];
    int          w_cur [3];
    logic [2:0]  e_gnt [3];
    logic [2:0]  e_rv [3];
    logic [31:0] e_rd [3];
    logic [31:0] m_saddr [3];
    logic [31:0] m_swd [3];
    logic        m_swr [3];
    logic        m_srd [3];
    int          sch_id [3][8];
    logic [31:0] sch_dat [3][8];

    function automatic int nm_of(input int d);
        return (d == 2) ? 3 : 2;
    endfunction

    function automatic int lat_of(input int d);
        return (d == 1) ? 2 : 1;
    endfunction

    task automatic model_reset(input int d);
        ptr[d] = 0; m_swr[d] = 1'b0; m_srd[d] = 1'b0; m_saddr[d] = '0; m_swd[d] = '0;
        e_rv[d] = '0; e_rd[d] = '0;
        for (int s = 0; s < 8; s++) sch_id[d][s] = -1;
    endtask

    task automatic eval_comb();
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            w_cur[d] = -1;
            if (resetn) begin
                for (int k = 0; k < nm_of(d); k++) begin
                    if (w_cur[d] < 0 && rq[d][(ptr[d] + k) % nm_of(d)])
                        w_cur[d] = (ptr[d] + k) % nm_of(d);
                end
            end
            e_gnt[d] = (w_cur[d] >= 0) ? 3'(1 << w_cur[d]) : 3'b000;
        end
    endtask

    task automatic advance();
        int w;
        @(posedge clk);
        #1;
        cyc++;
        for (int d = 0; d < 3; d++) begin
            w = w_cur[d];
            if (!resetn) begin
                model_reset(d);
            end else begin
                if (w >= 0) begin
                    ptr[d]     = (w + 1) % nm_of(d);
                    m_saddr[d] = ad[d][w];
                    m_swd[d]   = wd[d][w];
                    m_swr[d]   = we[d][w];
                    m_srd[d]   = !we[d][w];
                    if (!we[d][w]) begin
                        sch_id[d][(cyc + lat_of(d) + 1) % 8]  = w;
                        sch_dat[d][(cyc + lat_of(d) + 1) % 8] = ad[d][w] ^ C_KEY;
                    end
                end else begin
                    m_swr[d] = 1'b0;
                    m_srd[d] = 1'b0;
                end
                if (sch_id[d][cyc % 8] >= 0) begin
                    e_rv[d] = 3'(1 << sch_id[d][cyc % 8]);
                    e_rd[d] = sch_dat[d][cyc % 8];
                    sch_id[d][cyc % 8] = -1;
                end else begin
                    e_rv[d] = '0;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int d = 0; d < 3; d++) rq[d] = '0;
        repeat (n) begin
            eval_comb();
            advance();
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        for (int d = 0; d < 3; d++) begin
            rq[d] = (d == 2) ? 3'b111 : 3'b011;
            we[d] = '0;
            for (int m = 0; m < 3; m++) begin ad[d][m] = $urandom; wd[d][m] = $urandom; end
        end
        repeat (3) begin
            eval_comb();
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (gnt_v[d] !== 3'b000) begin
                    errors++; $display("FAIL reset_gnt dut%0d: got %b want 000", d, gnt_v[d]);
                end
            end
            advance();
            for (int d = 0; d < 3; d++) begin
                checks++;
                if ({swr_v[d], srd_v[d], rv_v[d], rdat_v[d], saddr_v[d], swd_v[d]} !== '0) begin
                    errors++;
                    $display("FAIL reset_regs dut%0d: wr=%b rd=%b rv=%b rdata=%h addr=%h wdata=%h want all 0",
                             d, swr_v[d], srd_v[d], rv_v[d], rdat_v[d], saddr_v[d], swd_v[d]);
                end
            end
        end
        resetn = 1'b1;
        eval_comb();
        checks++;
        if (gnt_v[0] !== 3'b001) begin
            errors++; $display("FAIL release_gnt dut0: got %b want 001", gnt_v[0]);
        end
        checks++;
        if (gnt_v[2] !== 3'b001) begin
            errors++; $display("FAIL release_gnt dut2: got %b want 001", gnt_v[2]);
        end
        advance();
        idle(5);
    endtask

    task automatic test_fairness();
        logic [2:0] prev;
        prev = '0;
        we[0] = '0;
        for (int i = 0; i < 16; i++) begin
            rq[0] = (i < 12) ? 3'b011 : 3'b000;
            ad[0][0] = $urandom; ad[0][1] = $urandom;
            eval_comb();
            checks++;
            if (gnt_v[0] !== e_gnt[0]) begin
                errors++; $display("FAIL fair_gnt cyc%0d: got %b want %b", i, gnt_v[0], e_gnt[0]);
            end
            if (i > 0 && i < 12) begin
                checks++;
                if (gnt_v[0] === prev) begin
                    errors++; $display("FAIL fair_alternate cyc%0d: got %b want not %b", i, gnt_v[0], prev);
                end
            end
            prev = gnt_v[0];
            advance();
            checks++;
            if (rv_v[0] !== e_rv[0] || (e_rv[0] != 0 && rdat_v[0] !== e_rd[0])) begin
                errors++;
                $display("FAIL fair_resp cyc%0d: got rv=%b data=%h want rv=%b data=%h",
                         i, rv_v[0], rdat_v[0], e_rv[0], e_rd[0]);
            end
        end
    endtask

    task automatic test_write();
        idle(4);
        rq[0] = 3'b010; we[0] = 3'b010; ad[0][1] = 32'h0040_0008; wd[0][1] = 32'h41;
        eval_comb();
        checks++;
        if (gnt_v[0] !== 3'b010) begin
            errors++; $display("FAIL write_gnt: got %b want 010", gnt_v[0]);
        end
        advance();
        rq[0] = '0;
        checks++;
        if ({swr_v[0], srd_v[0], saddr_v[0], swd_v[0]} !== {1'b1, 1'b0, 32'h0040_0008, 32'h41}) begin
            errors++;
            $display("FAIL write_cmd: got wr=%b rd=%b addr=%h wdata=%h want wr=1 rd=0 addr=00400008 wdata=00000041",
                     swr_v[0], srd_v[0], saddr_v[0], swd_v[0]);
        end
        repeat (5) begin
            eval_comb();
            advance();
            checks++;
            if (rv_v[0] !== 3'b000) begin
                errors++; $display("FAIL write_no_resp: got rv=%b want 000", rv_v[0]);
            end
        end
    endtask

    task automatic test_read_pipe();
        logic [31:0] addrs [3];
        logic [2:0]  want_id [3];
        logic [2:0]  got_id [3];
        logic [31:0] got_dat [3];
        int          got_cyc [3];
        int          n;
        addrs[0] = 32'h10; addrs[1] = 32'h20; addrs[2] = 32'h30;
        want_id[0] = 3'b001; want_id[1] = 3'b010; want_id[2] = 3'b001;
        n = 0;
        idle(4);
        we[1] = '0;
        for (int i = 0; i < 10; i++) begin
            if (i < 3) begin
                rq[1] = want_id[i];
                ad[1][(i == 1) ? 1 : 0] = addrs[i];
            end else begin
                rq[1] = '0;
            end
            eval_comb();
            checks++;
            if (gnt_v[1] !== e_gnt[1]) begin
                errors++; $display("FAIL pipe_gnt cyc%0d: got %b want %b", i, gnt_v[1], e_gnt[1]);
            end
            advance();
            checks++;
            if (rv_v[1] !== e_rv[1] || (e_rv[1] != 0 && rdat_v[1] !== e_rd[1])) begin
                errors++;
                $display("FAIL pipe_resp cyc%0d: got rv=%b data=%h want rv=%b data=%h",
                         i, rv_v[1], rdat_v[1], e_rv[1], e_rd[1]);
            end
            if (rv_v[1] != 0 && n < 3) begin
                got_id[n] = rv_v[1]; got_dat[n] = rdat_v[1]; got_cyc[n] = i; n++;
            end
        end
        checks++;
        if (n != 3) begin
            errors++; $display("FAIL pipe_count: got %0d pulses want 3", n);
        end
        for (int k = 0; k < n; k++) begin
            checks++;
            if (got_id[k] !== want_id[k] || got_dat[k] !== (addrs[k] ^ C_KEY) ||
                got_cyc[k] != got_cyc[0] + k) begin
                errors++;
                $display("FAIL pipe_order #%0d: got id=%b data=%h at +%0d want id=%b data=%h at +%0d",
                         k, got_id[k], got_dat[k], got_cyc[k] - got_cyc[0], want_id[k],
                         addrs[k] ^ C_KEY, k);
            end
        end
    endtask

    task automatic test_reset_mid_read();
        idle(4);
        rq[1] = 3'b001; we[1] = '0; ad[1][0] = 32'h44;
        eval_comb();
        checks++;
        if (gnt_v[1] !== 3'b001) begin
            errors++; $display("FAIL midrst_gnt: got %b want 001", gnt_v[1]);
        end
        advance();
        rq[1] = '0;
        resetn = 1'b0;
        repeat (2) begin eval_comb(); advance(); end
        resetn = 1'b1;
        repeat (6) begin
            eval_comb();
            advance();
            checks++;
            if (rv_v[1] !== 3'b000) begin
                errors++; $display("FAIL midrst_resp: got rv=%b want 000", rv_v[1]);
            end
        end
    endtask

    task automatic test_starvation();
        int         m2_at;
        logic [2:0] after;
        m2_at = -1;
        after = 3'bxxx;
        idle(4);
        for (int i = 0; i < 10; i++) begin
            rq[2] = (i < 5) ? 3'b011 : 3'b111;
            we[2] = 3'($urandom);
            for (int m = 0; m < 3; m++) begin ad[2][m] = $urandom; wd[2][m] = $urandom; end
            eval_comb();
            checks++;
            if (gnt_v[2] !== e_gnt[2]) begin
                errors++; $display("FAIL starve_gnt cyc%0d: got %b want %b", i, gnt_v[2], e_gnt[2]);
            end
            if (m2_at >= 0 && i == m2_at + 1) after = gnt_v[2];
            if (m2_at < 0 && gnt_v[2] === 3'b100) m2_at = i;
            advance();
            checks++;
            if (rv_v[2] !== e_rv[2] || (e_rv[2] != 0 && rdat_v[2] !== e_rd[2])) begin
                errors++;
                $display("FAIL starve_resp cyc%0d: got rv=%b data=%h want rv=%b data=%h",
                         i, rv_v[2], rdat_v[2], e_rv[2], e_rd[2]);
            end
        end
        rq[2] = '0;
        checks++;
        if (m2_at < 5 || m2_at > 7) begin
            errors++; $display("FAIL starve_m2: got grant at cycle %0d want 5..7", m2_at);
        end
        checks++;
        if (after !== 3'b001) begin
            errors++; $display("FAIL starve_next: got %b want 001", after);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            resetn = ($urandom_range(0, 59) != 0);
            for (int d = 0; d < 3; d++) begin
                rq[d] = 3'($urandom) & ((d == 2) ? 3'b111 : 3'b011);
                we[d] = 3'($urandom);
                for (int m = 0; m < 3; m++) begin ad[d][m] = $urandom; wd[d][m] = $urandom; end
            end
            eval_comb();
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (gnt_v[d] !== e_gnt[d]) begin
                    errors++; $display("FAIL rnd_gnt dut%0d cyc%0d: got %b want %b", d, i, gnt_v[d], e_gnt[d]);
                end
            end
            advance();
            for (int d = 0; d < 3; d++) begin
                checks++;
                if ({swr_v[d], srd_v[d]} !== {m_swr[d], m_srd[d]}) begin
                    errors++; $display("FAIL rnd_strobe dut%0d cyc%0d: got wr/rd=%b%b want %b%b",
                                       d, i, swr_v[d], srd_v[d], m_swr[d], m_srd[d]);
                end
                checks++;
                if (saddr_v[d] !== m_saddr[d] || swd_v[d] !== m_swd[d]) begin
                    errors++; $display("FAIL rnd_cmd dut%0d cyc%0d: got addr=%h wdata=%h want addr=%h wdata=%h",
                                       d, i, saddr_v[d], swd_v[d], m_saddr[d], m_swd[d]);
                end
                checks++;
                if (rv_v[d] !== e_rv[d] || rdat_v[d] !== e_rd[d]) begin
                    errors++; $display("FAIL rnd_resp dut%0d cyc%0d: got rv=%b data=%h want rv=%b data=%h",
                                       d, i, rv_v[d], rdat_v[d], e_rv[d], e_rd[d]);
                end
            end
        end
        resetn = 1'b1;
        idle(4);
    endtask

    initial begin
        resetn = 1'b0;
        for (int d = 0; d < 3; d++) begin
            rq[d] = '0; we[d] = '0;
            for (int m = 0; m < 3; m++) begin ad[d][m] = '0; wd[d][m] = '0; end
            model_reset(d);
            w_cur[d] = -1;
            e_gnt[d] = '0;
        end
        test_reset();
        test_fairness();
        test_write();
        test_read_pipe();
        test_reset_mid_read();
        test_starvation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
